// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the instruction-memory loader.
// A byte transfers on any rising clk edge where in_valid && in_ready; in_data is held stable while in_valid waits.
interface imem_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a framed byte stream (sync, 16-bit word count, big-endian data, XOR checksum)
// and writes the words into the instruction memory from address 0, holding the CPU until the frame checks out.
module imem_loader #(
  parameter int         ADDR_W    = 9,
  parameter int         MEM_SIZE  = 512,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  imem_loader_if.slave      in_if,
  input  logic              restart,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        chk_q, chk_d;
  logic              in_ready_q, in_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
  logic              accept;
  logic [15:0]       hdr_cnt;

  assign accept = in_if.in_valid && in_ready_q;

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    byte_idx_d     = byte_idx_q;
    word_d         = word_q;
    chk_d          = chk_q;
    we_d           = 1'b0;
    waddr_d        = waddr_q;
    wdata_d        = wdata_q;
    words_loaded_d = words_loaded_q;
    hdr_cnt        = {count_q[15:8], in_if.in_data};

    case (state_q)
      IDLE: begin
        if (accept && in_if.in_data == SYNC_BYTE) state_d = HDR_HI;
      end
      HDR_HI: begin
        if (accept) begin
          count_d[15:8] = in_if.in_data;
          state_d       = HDR_LO;
        end
      end
      HDR_LO: begin
        if (accept) begin
          count_d = hdr_cnt;
          if (hdr_cnt == 16'd0 || 32'(hdr_cnt) > MEM_SIZE) begin
            state_d = ERR;
          end else begin
            state_d        = DATA;
            waddr_d        = '0;
            byte_idx_d     = 2'd0;
            chk_d          = 8'd0;
            words_loaded_d = '0;
          end
        end
      end
      DATA: begin
        if (accept) begin
          word_d     = {word_q[23:0], in_if.in_data};
          chk_d      = chk_q ^ in_if.in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          // Write is issued from registers the cycle after the 4th byte; the index advances with it.
          if (byte_idx_q == 2'd3) begin
            we_d           = 1'b1;
            wdata_d        = word_d;
            waddr_d        = words_loaded_q[ADDR_W-1:0];
            words_loaded_d = words_loaded_q + 1'b1;
            if (16'(words_loaded_d) == count_q) state_d = CHK;
          end
        end
      end
      CHK: begin
        if (accept) state_d = (in_if.in_data == chk_q) ? DONE : ERR;
      end
      DONE, ERR: begin
        if (restart) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = !(state_d == DONE || state_d == ERR);
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERR);
    cpu_hold_d = (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      count_q        <= '0;
      byte_idx_q     <= '0;
      word_q         <= '0;
      chk_q          <= '0;
      in_ready_q     <= 1'b1;
      we_q           <= 1'b0;
      waddr_q        <= '0;
      wdata_q        <= '0;
      cpu_hold_q     <= 1'b1;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      byte_idx_q     <= byte_idx_d;
      word_q         <= word_d;
      chk_q          <= chk_d;
      in_ready_q     <= in_ready_d;
      we_q           <= we_d;
      waddr_q        <= waddr_d;
      wdata_q        <= wdata_d;
      cpu_hold_q     <= cpu_hold_d;
      done_q         <= done_d;
      err_q          <= err_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign we             = we_q;
  assign waddr          = waddr_q;
  assign wdata          = wdata_q;
  assign cpu_hold       = cpu_hold_q;
  assign done           = done_q;
  assign err            = err_q;
  assign words_loaded   = words_loaded_q;
  assign dbg_state      = state_q;

endmodule
